// File: rtl/rescale_line_buffer.sv
// Two-row source line buffer feeding the rescale core.
// Rows are pulled from the pixel stream only while the core has a request open.
// The core then reads the 2x2 bilinear neighbourhood at any column.
module rescale_line_buffer #(
  parameter int SRC_W = 320
) (
  input  logic        CLOCK,
  input  logic        RESETN,
  input  logic [31:0] S_AXIS_TDATA,
  input  logic        S_AXIS_TVALID,
  output logic        S_AXIS_TREADY,
  input  logic        S_AXIS_TLAST,
  input  logic        in_stream_ready,
  input  logic [8:0]  row_to_wait,
  input  logic        skip,
  output logic        buffer_done,
  input  logic [10:0] neighbor_offset,
  output logic [15:0] neighbor0,
  output logic [15:0] neighbor1,
  output logic [15:0] neighbor2,
  output logic [15:0] neighbor3,
  output logic        framing_error
);

  localparam int WORDS_PER_ROW = SRC_W / 2;
  localparam int WC_W = (WORDS_PER_ROW > 1) ? $clog2(WORDS_PER_ROW) : 1;
  localparam int AW = WC_W + 1;
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(WORDS_PER_ROW - 1);
  localparam logic [10:0] COL_MAX = 11'(SRC_W - 1);
  localparam logic [10:0] COL_LIM = 11'(SRC_W);

  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

  state_t          state;
  state_t          state_nxt;
  logic            sel;
  logic [WC_W-1:0] word_cnt;
  logic [8:0]      rows_left;
  logic            skip_q;

  // Bank contents carry no reset; only the control path is initialised.
  logic [15:0] bank0 [SRC_W];
  logic [15:0] bank1 [SRC_W];

  logic          accept;
  logic          row_end;
  logic [AW-1:0] wa_even;
  logic [AW-1:0] wa_odd;
  logic [10:0]   c_p0;
  logic [11:0]   c1_full_p0;
  logic [10:0]   c1_p0;
  logic [AW-1:0] ra0_p0;
  logic [AW-1:0] ra1_p0;

  // TREADY is high for the whole of FILL, so TVALID alone marks an accepted word.
  assign accept  = (state == FILL) && S_AXIS_TVALID;
  assign row_end = accept && (word_cnt == WC_LAST);
  assign wa_even = {word_cnt, 1'b0};
  assign wa_odd  = {word_cnt, 1'b1};

  // Stage 0: clamp the requested column and its right-hand neighbour.
  // An out-of-range column collapses onto the last pixel, which also pins c+1 there.
  assign c_p0       = (neighbor_offset >= COL_LIM) ? COL_MAX : neighbor_offset;
  assign c1_full_p0 = {1'b0, c_p0} + 12'd1;
  assign c1_p0      = (c1_full_p0 > {1'b0, COL_MAX}) ? COL_MAX : c1_full_p0[10:0];
  assign ra0_p0     = c_p0[AW-1:0];
  assign ra1_p0     = c1_p0[AW-1:0];

  // State register.
  always_ff @(posedge CLOCK or negedge RESETN) begin
    if (!RESETN) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state decode and request handshake outputs.
  always_comb begin
    state_nxt     = state;
    S_AXIS_TREADY = 1'b0;
    buffer_done   = 1'b0;
    case (state)
      IDLE: begin
        if (in_stream_ready) state_nxt = (row_to_wait == 9'd0) ? DONE : FILL;
      end
      FILL: begin
        S_AXIS_TREADY = 1'b1;
        if (row_end && (rows_left == 9'd1)) state_nxt = DONE;
      end
      DONE: begin
        buffer_done = 1'b1;
        if (!in_stream_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request bookkeeping, row counting, bank rotation and framing check.
  // A misplaced TLAST only raises the flag; counting always follows word_cnt.
  always_ff @(posedge CLOCK or negedge RESETN) begin
    if (!RESETN) begin
      sel           <= 1'b0;
      word_cnt      <= '0;
      rows_left     <= '0;
      skip_q        <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      if ((state == IDLE) && in_stream_ready) begin
        rows_left <= row_to_wait;
        skip_q    <= skip;
      end
      if (accept) begin
        if (row_end) begin
          word_cnt  <= '0;
          rows_left <= rows_left - 9'd1;
          if (!skip_q)       sel           <= ~sel;
          if (!S_AXIS_TLAST) framing_error <= 1'b1;
        end else begin
          word_cnt <= word_cnt + 1'b1;
          if (S_AXIS_TLAST)  framing_error <= 1'b1;
        end
      end
    end
  end

  // Incoming pixels overwrite the older row (top) in place; sel flips once it is whole.
  always_ff @(posedge CLOCK) begin
    if (accept && !skip_q) begin
      if (sel) begin
        bank1[wa_even] <= S_AXIS_TDATA[15:0];
        bank1[wa_odd]  <= S_AXIS_TDATA[31:16];
      end else begin
        bank0[wa_even] <= S_AXIS_TDATA[15:0];
        bank0[wa_odd]  <= S_AXIS_TDATA[31:16];
      end
    end
  end

  // Stage 1: registered neighbourhood read, frozen while a row is being filled.
  always_ff @(posedge CLOCK or negedge RESETN) begin
    if (!RESETN) begin
      neighbor0 <= '0;
      neighbor1 <= '0;
      neighbor2 <= '0;
      neighbor3 <= '0;
    end else if (state != FILL) begin
      neighbor0 <= sel ? bank1[ra0_p0] : bank0[ra0_p0];
      neighbor1 <= sel ? bank1[ra1_p0] : bank0[ra1_p0];
      neighbor2 <= sel ? bank0[ra0_p0] : bank1[ra0_p0];
      neighbor3 <= sel ? bank0[ra1_p0] : bank1[ra1_p0];
    end
  end

endmodule

// File: tb/tb_rescale_line_buffer.sv
// Bench for rescale_line_buffer: request-level stimulus with random stream gaps,
// a row-level reference of the two stored rows, and literal neighbourhood checks.
module tb_rescale_line_buffer;

  localparam int SRC_W = 8;
  localparam int WPR   = SRC_W / 2;
  localparam int CW    = $clog2(SRC_W);

  logic        CLOCK = 1'b0;
  logic        RESETN = 1'b0;
  logic [31:0] S_AXIS_TDATA = '0;
  logic        S_AXIS_TVALID = 1'b0;
  logic        S_AXIS_TREADY;
  logic        S_AXIS_TLAST = 1'b0;
  logic        in_stream_ready = 1'b0;
  logic [8:0]  row_to_wait = '0;
  logic        skip = 1'b0;
  logic        buffer_done;
  logic [10:0] neighbor_offset = '0;
  logic [15:0] neighbor0, neighbor1, neighbor2, neighbor3;
  logic        framing_error;

  int checks = 0;
  int errors = 0;

  // Reference: two row stores, which one is "top", and which pixels are known.
  logic [15:0] mb [2][SRC_W];
  bit          mv [2][SRC_W];
  bit          msel = 1'b0;
  bit          fill_now = 1'b0;
  logic [15:0] e0 = '0, e1 = '0, e2 = '0, e3 = '0;
  bit          e_ok = 1'b0;

  rescale_line_buffer #(.SRC_W(SRC_W)) dut (
    .CLOCK(CLOCK), .RESETN(RESETN),
    .S_AXIS_TDATA(S_AXIS_TDATA), .S_AXIS_TVALID(S_AXIS_TVALID),
    .S_AXIS_TREADY(S_AXIS_TREADY), .S_AXIS_TLAST(S_AXIS_TLAST),
    .in_stream_ready(in_stream_ready), .row_to_wait(row_to_wait), .skip(skip),
    .buffer_done(buffer_done), .neighbor_offset(neighbor_offset),
    .neighbor0(neighbor0), .neighbor1(neighbor1),
    .neighbor2(neighbor2), .neighbor3(neighbor3),
    .framing_error(framing_error)
  );

  always #5 CLOCK = ~CLOCK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, want, $time);
    end
  endtask

  // Expected neighbourhood for the offset seen at each edge outside a fill.
  always @(posedge CLOCK) begin
    int c, c1;
    if (!RESETN) begin
      e0 = '0; e1 = '0; e2 = '0; e3 = '0;
      e_ok = 1'b1;
    end else if (!fill_now) begin
      c  = (int'(neighbor_offset) >= SRC_W) ? SRC_W - 1 : int'(neighbor_offset);
      c1 = (c + 1 > SRC_W - 1) ? SRC_W - 1 : c + 1;
      e0 = mb[msel][CW'(c)];
      e1 = mb[msel][CW'(c1)];
      e2 = mb[!msel][CW'(c)];
      e3 = mb[!msel][CW'(c1)];
      e_ok = mv[msel][CW'(c)] && mv[msel][CW'(c1)] &&
             mv[!msel][CW'(c)] && mv[!msel][CW'(c1)];
    end
  end

  // Compare the DUT neighbourhood against the reference every cycle it is defined.
  always @(negedge CLOCK) begin
    if (RESETN && e_ok) begin
      chk("cmp_n0", neighbor0, e0);
      chk("cmp_n1", neighbor1, e1);
      chk("cmp_n2", neighbor2, e2);
      chk("cmp_n3", neighbor3, e3);
    end
  end

  // One core request: nrows rows; base<0 means random pixels, else (base+r)<<8|col.
  // bad_word toggles TLAST on that word of the first row; abort_after resets mid-row.
  task automatic request(input int nrows, input bit sk, input int base,
                         input int bad_word, input int abort_after);
    logic [31:0] wq[$];
    bit          lq[$];
    int acc = 0, cyc = 0, idx = 0, extra = 0;
    bit seen = 1'b0, rdy, vld;
    for (int r = 0; r < nrows; r++) begin
      for (int w = 0; w < WPR; w++) begin
        logic [15:0] lo, hi;
        if (base >= 0) begin
          lo = 16'(((base + r) << 8) | (2 * w));
          hi = 16'(((base + r) << 8) | (2 * w + 1));
        end else begin
          lo = 16'($urandom);
          hi = 16'($urandom);
        end
        wq.push_back({hi, lo});
        lq.push_back((w == WPR - 1) ^ (r == 0 && w == bad_word));
      end
    end
    @(negedge CLOCK);
    in_stream_ready = 1'b1;
    row_to_wait     = 9'(nrows);
    skip            = sk;
    @(negedge CLOCK);
    if (nrows > 0) fill_now = 1'b1;
    while (cyc < 200) begin
      if (buffer_done) begin
        seen = 1'b1;
        break;
      end
      rdy = S_AXIS_TREADY;
      neighbor_offset = 11'($urandom_range(0, 20));
      if (idx < wq.size()) begin
        vld = ($urandom_range(0, 3) != 0);
        S_AXIS_TDATA  = wq[idx];
        S_AXIS_TLAST  = lq[idx];
        S_AXIS_TVALID = vld;
        if (vld && rdy) begin
          if (!sk) begin
            mb[msel][CW'(2 * (idx % WPR))]     = wq[idx][15:0];
            mb[msel][CW'(2 * (idx % WPR) + 1)] = wq[idx][31:16];
            mv[msel][CW'(2 * (idx % WPR))]     = 1'b1;
            mv[msel][CW'(2 * (idx % WPR) + 1)] = 1'b1;
            if (idx % WPR == WPR - 1) msel = !msel;
          end
          idx++;
          acc++;
          if (abort_after > 0 && acc == abort_after) begin
            @(posedge CLOCK);
            #1;
            RESETN          = 1'b0;
            msel            = 1'b0;
            fill_now        = 1'b0;
            S_AXIS_TVALID   = 1'b0;
            in_stream_ready = 1'b0;
            #1;
            chk("rst_tready", S_AXIS_TREADY, 0);
            chk("rst_done", buffer_done, 0);
            chk("rst_ferr", framing_error, 0);
            repeat (2) @(negedge CLOCK);
            RESETN = 1'b1;
            return;
          end
        end
      end else begin
        S_AXIS_TVALID = 1'b0;
        if (rdy) extra++;
      end
      @(negedge CLOCK);
      cyc++;
    end
    S_AXIS_TVALID = 1'b0;
    fill_now      = 1'b0;
    chk("done_seen", seen, 1);
    chk("words_taken", acc, nrows * WPR);
    chk("extra_ready", extra, 0);
    chk("ready_in_done", S_AXIS_TREADY, 0);
    if (nrows == 0) chk("zero_row_latency", cyc, 0);
    in_stream_ready = 1'b0;
    @(negedge CLOCK);
    chk("done_fall", buffer_done, 0);
    chk("ready_idle", S_AXIS_TREADY, 0);
  endtask

  task automatic read_lit(input int off, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] c, input logic [15:0] d);
    @(negedge CLOCK);
    neighbor_offset = 11'(off);
    @(negedge CLOCK);
    chk("lit_n0", neighbor0, a);
    chk("lit_n1", neighbor1, b);
    chk("lit_n2", neighbor2, c);
    chk("lit_n3", neighbor3, d);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge CLOCK);
    chk("reset_tready", S_AXIS_TREADY, 0);
    chk("reset_done", buffer_done, 0);
    chk("reset_n0", neighbor0, 0);
    chk("reset_n3", neighbor3, 0);
    chk("reset_ferr", framing_error, 0);
    RESETN = 1'b1;

    // Rows A, B: top=A, bot=B.
    request(2, 1'b0, 1, -1, -1);
    read_lit(3, 16'h0103, 16'h0104, 16'h0203, 16'h0204);
    // Row C: top=B, bot=C; right edge and out-of-range clamp.
    request(1, 1'b0, 3, -1, -1);
    read_lit(7, 16'h0207, 16'h0207, 16'h0307, 16'h0307);
    read_lit(20, 16'h0207, 16'h0207, 16'h0307, 16'h0307);
    // Skipped rows leave storage and bank order untouched.
    request(2, 1'b1, 8, -1, -1);
    read_lit(3, 16'h0203, 16'h0204, 16'h0303, 16'h0304);
    // Empty request.
    request(0, 1'b0, 0, -1, -1);
    // Early TLAST on word 1; row E still stored: top=C, bot=E.
    chk("ferr_before", framing_error, 0);
    request(1, 1'b0, 5, 1, -1);
    chk("ferr_early_last", framing_error, 1);
    read_lit(2, 16'h0302, 16'h0303, 16'h0502, 16'h0503);
    request(0, 1'b0, 0, -1, -1);
    chk("ferr_sticky", framing_error, 1);
    // Reset after two words of row F, then row D restarts at column 0.
    request(1, 1'b0, 6, -1, 2);
    request(1, 1'b0, 4, -1, -1);
    read_lit(0, 16'h0500, 16'h0501, 16'h0400, 16'h0401);
    // Missing TLAST on the final word; row G still completes: top=D, bot=G.
    chk("ferr_after_reset", framing_error, 0);
    request(1, 1'b0, 7, 3, -1);
    chk("ferr_missing_last", framing_error, 1);
    read_lit(5, 16'h0405, 16'h0406, 16'h0705, 16'h0706);

    // Random requests and random reads, checked by the reference.
    for (int i = 0; i < 8; i++) begin
      request($urandom_range(1, 3), 1'($urandom_range(0, 1)), -1, -1, -1);
      for (int k = 0; k < 4; k++) begin
        @(negedge CLOCK);
        neighbor_offset = 11'($urandom_range(0, 2047));
      end
    end
    repeat (2) @(negedge CLOCK);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
